// File: rtl/cpu7_ifu_imem_resp.sv
`default_nettype none
// ============================================================================
// Module   : cpu7_ifu_imem_resp
// Purpose  : Responder end of the IFU instruction-fetch interface. Accepts
//            fetch requests, issues word reads to an in-order instruction
//            SRAM port and returns results in acceptance order through a
//            small completion buffer. Handles branch-redirect cancel and
//            raises an address-misalign exception for unaligned fetches.
// Ports    : clock/reset          - clock, synchronous active-high reset
//            inst_req/inst_addr   - fetch request from the IFU
//            inst_cancel          - kill every fetch accepted before now
//            inst_addr_ok         - request accepted this cycle (comb)
//            inst_valid/rdata/... - registered fetch result
//            mem_req/addr/gnt     - memory read request handshake
//            mem_rvalid/rdata     - in-order read data return
// Revision : 1.0 - initial release
// ============================================================================
module cpu7_ifu_imem_resp #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] UC_MASK  = 32'hE000_0000,
    parameter logic [31:0] UC_MATCH = 32'hA000_0000,
    parameter logic [5:0]  EXC_ADEF = 6'h08
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inst_req,
    input  logic [31:0]  inst_addr,
    input  logic         inst_cancel,
    output logic         inst_addr_ok,
    output logic         inst_valid,
    output logic [127:0] inst_rdata,
    output logic [1:0]   inst_count,
    output logic         inst_ex,
    output logic [5:0]   inst_exccode,
    output logic         inst_uncache,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata
);

    localparam int                  c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);

    // Completion buffer entries
    logic        r_valid  [DEPTH];
    logic        r_cancel [DEPTH];
    logic        r_ex     [DEPTH];
    logic        r_uc     [DEPTH];
    logic        r_done   [DEPTH];
    logic [31:0] r_data   [DEPTH];

    logic [c_PTR_W-1:0] r_alloc;
    logic [c_PTR_W-1:0] r_head;
    logic [c_CNT_W-1:0] r_count;

    // Granted-but-unreturned reads. Deliberately kept out of reset so that
    // reads issued before a reset can still be accounted for afterwards.
    logic [c_CNT_W-1:0] r_inflight;
    logic               r_drain;

    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_ex;
    logic        r_out_uc;

    logic               w_full;
    logic               w_mis;
    logic               w_uc;
    logic               w_can_acc;
    logic               w_accept;
    logic               w_mis_bypass;
    logic               w_do_alloc;
    logic               w_grant;
    logic               w_ret_mem;
    logic [c_CNT_W-1:0] w_inflight_next;
    logic [c_PTR_W-1:0] w_scan_idx;
    logic [c_PTR_W-1:0] w_mem_ptr;
    logic               w_mem_found;
    logic               w_rv;
    logic               w_bypass;
    logic               w_head_done;
    logic               w_retire;
    logic               w_ret_live;
    logic [31:0]        w_ret_data;
    logic               w_ret_ex;
    logic               w_ret_uc;

    assign w_full    = (r_count == c_FULL);
    assign w_mis     = (inst_addr[1:0] != 2'b00);
    assign w_uc      = ((inst_addr & UC_MASK) == UC_MATCH);
    assign w_can_acc = inst_req & ~w_full & ~reset & ~r_drain;

    assign mem_req      = w_can_acc & ~w_mis;
    assign mem_addr     = {inst_addr[31:2], 2'b00};
    assign w_grant      = mem_req & mem_gnt;
    assign w_accept     = w_mis ? w_can_acc : w_grant;
    assign inst_addr_ok = w_accept;

    // A misaligned fetch into an empty buffer would be at head immediately,
    // so it is returned straight away instead of taking a slot.
    assign w_mis_bypass = w_accept & w_mis & (r_count == '0);
    assign w_do_alloc   = w_accept & ~w_mis_bypass;

    // Oldest live entry still waiting for memory data; exception entries
    // never issue a read and are skipped.
    always_comb begin
        w_mem_found = 1'b0;
        w_mem_ptr   = r_head;
        w_scan_idx  = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan_idx = r_head + c_PTR_W'(i);
            if (!w_mem_found && r_valid[w_scan_idx] && !r_done[w_scan_idx] && !r_ex[w_scan_idx]) begin
                w_mem_found = 1'b1;
                w_mem_ptr   = w_scan_idx;
            end
        end
    end

    // Returns that belong to reads issued before a reset are absorbed.
    assign w_rv        = mem_rvalid & ~r_drain & w_mem_found;
    assign w_bypass    = w_rv & (w_mem_ptr == r_head);
    assign w_head_done = r_valid[r_head] & r_done[r_head];
    assign w_retire    = w_head_done | w_bypass | w_mis_bypass;

    always_comb begin
        w_ret_live = 1'b0;
        w_ret_data = 32'h0;
        w_ret_ex   = 1'b0;
        w_ret_uc   = 1'b0;
        if (w_mis_bypass) begin
            // The request accepted alongside a cancel is the redirect target.
            w_ret_live = 1'b1;
            w_ret_ex   = 1'b1;
            w_ret_uc   = w_uc;
        end else begin
            w_ret_live = ~r_cancel[r_head] & ~inst_cancel;
            w_ret_data = w_bypass ? mem_rdata : r_data[r_head];
            w_ret_ex   = r_ex[r_head];
            w_ret_uc   = r_uc[r_head];
        end
    end

    assign w_ret_mem       = mem_rvalid & (r_inflight != '0);
    assign w_inflight_next = r_inflight + c_CNT_W'(w_grant) - c_CNT_W'(w_ret_mem);

    always_ff @(posedge clock) begin
        r_inflight <= w_inflight_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_drain <= (w_inflight_next != '0);
        end else if (w_inflight_next == '0) begin
            r_drain <= 1'b0;
        end
    end

    // Buffer state. Later assignments take precedence: an allocation in the
    // cancel cycle clears the cancel flag set by the broadcast above it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_cancel[i] <= 1'b0;
                r_ex[i]     <= 1'b0;
                r_uc[i]     <= 1'b0;
                r_done[i]   <= 1'b0;
                r_data[i]   <= 32'h0;
            end
            r_alloc <= '0;
            r_head  <= '0;
            r_count <= '0;
        end else begin
            if (inst_cancel) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_cancel[i] <= 1'b1;
                end
            end
            if (w_rv) begin
                r_data[w_mem_ptr] <= mem_rdata;
                r_done[w_mem_ptr] <= 1'b1;
            end
            if (w_retire && !w_mis_bypass) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
            if (w_do_alloc) begin
                r_valid[r_alloc]  <= 1'b1;
                r_cancel[r_alloc] <= 1'b0;
                r_ex[r_alloc]     <= w_mis;
                r_done[r_alloc]   <= w_mis;
                r_uc[r_alloc]     <= w_uc;
                r_data[r_alloc]   <= 32'h0;
                r_alloc           <= r_alloc + c_PTR_ONE;
            end
            r_count <= r_count
                     + (w_do_alloc ? c_CNT_ONE : '0)
                     - ((w_retire && !w_mis_bypass) ? c_CNT_ONE : '0);
        end
    end

    // Result register; payload holds its value when nothing live retires.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_ex    <= 1'b0;
            r_out_uc    <= 1'b0;
        end else begin
            r_out_valid <= w_retire & w_ret_live;
            if (w_retire && w_ret_live) begin
                r_out_data <= w_ret_data;
                r_out_ex   <= w_ret_ex;
                r_out_uc   <= w_ret_uc;
            end
        end
    end

    assign inst_valid   = r_out_valid;
    assign inst_rdata   = {96'h0, r_out_data};
    assign inst_count   = 2'b00;
    assign inst_ex      = r_out_ex;
    assign inst_exccode = r_out_ex ? EXC_ADEF : 6'h00;
    assign inst_uncache = r_out_uc;

endmodule
`default_nettype wire

// File: tb/tb_cpu7_ifu_imem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu7_ifu_imem_resp
// Purpose  : Directed self-checking bench for cpu7_ifu_imem_resp. Inputs are
//            driven 1 time unit after the rising edge and outputs are sampled
//            3 time units after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu7_ifu_imem_resp;

    logic         clock;
    logic         reset;
    logic         inst_req;
    logic [31:0]  inst_addr;
    logic         inst_cancel;
    logic         inst_addr_ok;
    logic         inst_valid;
    logic [127:0] inst_rdata;
    logic [1:0]   inst_count;
    logic         inst_ex;
    logic [5:0]   inst_exccode;
    logic         inst_uncache;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    cpu7_ifu_imem_resp #(
        .DEPTH    (2),
        .UC_MASK  (32'hE000_0000),
        .UC_MATCH (32'hA000_0000),
        .EXC_ADEF (6'h08)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_cancel  (inst_cancel),
        .inst_addr_ok (inst_addr_ok),
        .inst_valid   (inst_valid),
        .inst_rdata   (inst_rdata),
        .inst_count   (inst_count),
        .inst_ex      (inst_ex),
        .inst_exccode (inst_exccode),
        .inst_uncache (inst_uncache),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0000;
        inst_cancel = 1'b0;
        mem_gnt     = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;

        // 1: reset held three cycles with a request pending
        repeat (3) tick();
        #2;
        chk_eq("rst_valid",   inst_valid,   0);
        chk_eq("rst_addr_ok", inst_addr_ok, 0);
        chk_eq("rst_mem_req", mem_req,      0);
        chk_eq("rst_rdata",   inst_rdata,   0);
        chk_eq("rst_ex",      inst_ex,      0);
        chk_eq("rst_exccode", inst_exccode, 0);
        chk_eq("rst_uncache", inst_uncache, 0);
        chk_eq("rst_count",   inst_count,   0);
        inst_req = 1'b0;
        mem_gnt  = 1'b0;
        reset    = 1'b0;

        // 2: aligned fetch, data two cycles after grant
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        mem_gnt   = 1'b1;
        #2;
        chk_eq("t2_mem_req",  mem_req,      1);
        chk_eq("t2_addr_ok",  inst_addr_ok, 1);
        chk_eq("t2_mem_addr", mem_addr,     32'h1C00_0000);
        tick();
        inst_req = 1'b0;
        mem_gnt  = 1'b0;
        #2;
        chk_eq("t2_wait_valid", inst_valid, 0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0280_0C05;
        #2;
        chk_eq("t2_rv_valid", inst_valid, 0);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk_eq("t2_valid",   inst_valid,   1);
        chk_eq("t2_rdata",   inst_rdata,   {96'h0, 32'h0280_0C05});
        chk_eq("t2_ex",      inst_ex,      0);
        chk_eq("t2_uncache", inst_uncache, 0);
        tick();
        #2;
        chk_eq("t2_one_pulse", inst_valid, 0);

        // 3: misaligned fetch into an empty buffer
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0002;
        #2;
        chk_eq("t3_addr_ok", inst_addr_ok, 1);
        chk_eq("t3_mem_req", mem_req,      0);
        tick();
        inst_req = 1'b0;
        #2;
        chk_eq("t3_valid",   inst_valid,   1);
        chk_eq("t3_ex",      inst_ex,      1);
        chk_eq("t3_exccode", inst_exccode, 6'h08);
        chk_eq("t3_rdata",   inst_rdata,   0);
        tick();
        #2;
        chk_eq("t3_one_pulse", inst_valid, 0);

        // 4: uncached aligned fetch, misaligned queued behind it
        inst_req  = 1'b1;
        inst_addr = 32'hA000_0000;
        mem_gnt   = 1'b1;
        #2;
        chk_eq("t4_a_addr_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h1C00_0006;
        mem_gnt   = 1'b0;
        #2;
        chk_eq("t4_m_addr_ok", inst_addr_ok, 1);
        chk_eq("t4_m_mem_req", mem_req,      0);
        tick();
        inst_req = 1'b0;
        #2;
        chk_eq("t4_hold1", inst_valid, 0);
        tick();
        #2;
        chk_eq("t4_hold2", inst_valid, 0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        #2;
        chk_eq("t4_hold3", inst_valid, 0);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk_eq("t4_a_valid", inst_valid,   1);
        chk_eq("t4_a_rdata", inst_rdata,   {96'h0, 32'h1111_2222});
        chk_eq("t4_a_uc",    inst_uncache, 1);
        chk_eq("t4_a_ex",    inst_ex,      0);
        tick();
        #2;
        chk_eq("t4_m_valid",   inst_valid,   1);
        chk_eq("t4_m_ex",      inst_ex,      1);
        chk_eq("t4_m_exccode", inst_exccode, 6'h08);
        chk_eq("t4_m_uc",      inst_uncache, 0);
        tick();
        #2;
        chk_eq("t4_idle", inst_valid, 0);

        // 5: fill buffer, then redirect with cancel
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0010;
        mem_gnt   = 1'b1;
        #2;
        chk_eq("t5_a0_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h1C00_0020;
        #2;
        chk_eq("t5_a1_ok", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h1C00_0030;
        #2;
        chk_eq("t5_full_ok",  inst_addr_ok, 0);
        chk_eq("t5_full_req", mem_req,      0);
        tick();
        inst_cancel = 1'b1;
        inst_addr   = 32'h1C00_0100;
        #2;
        chk_eq("t5_cancel_ok", inst_addr_ok, 0);
        tick();
        inst_cancel = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hDEAD_0001;
        #2;
        chk_eq("t5_prefull_ok", inst_addr_ok, 0);
        tick();
        mem_rdata = 32'hDEAD_0002;
        #2;
        chk_eq("t5_old0_valid", inst_valid,   0);
        chk_eq("t5_new_ok",     inst_addr_ok, 1);
        chk_eq("t5_new_addr",   mem_addr,     32'h1C00_0100);
        tick();
        inst_req  = 1'b0;
        mem_gnt   = 1'b0;
        mem_rdata = 32'h1234_ABCD;
        #2;
        chk_eq("t5_old1_valid", inst_valid, 0);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk_eq("t5_new_valid", inst_valid, 1);
        chk_eq("t5_new_rdata", inst_rdata, {96'h0, 32'h1234_ABCD});
        tick();
        #2;
        chk_eq("t5_idle", inst_valid, 0);

        // 6: reset with one read still outstanding
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0200;
        mem_gnt   = 1'b1;
        #2;
        chk_eq("t6_pre_ok", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0;
        mem_gnt  = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0300;
        mem_gnt   = 1'b1;
        #2;
        chk_eq("t6_stall_req", mem_req,      0);
        chk_eq("t6_stall_ok",  inst_addr_ok, 0);
        chk_eq("t6_rst_valid", inst_valid,   0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        #2;
        chk_eq("t6_stall_req2", mem_req, 0);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk_eq("t6_stale_valid", inst_valid,   0);
        chk_eq("t6_resume_req",  mem_req,      1);
        chk_eq("t6_resume_ok",   inst_addr_ok, 1);
        tick();
        inst_req   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h600D_600D;
        #2;
        chk_eq("t6_wait_valid", inst_valid, 0);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk_eq("t6_valid", inst_valid, 1);
        chk_eq("t6_rdata", inst_rdata, {96'h0, 32'h600D_600D});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
